// File: rtl/digit_cursor_ctrl.sv
// One-hot digit cursor with wrap/clamp movement, enable-mask skipping and direct load.
// Optional blink gating of the cursor is built when CURSOR_BLINK_EN is defined.
module digit_cursor_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int WRAP      = 1,
    parameter int RESET_POS = 0,
    parameter int BLINK_DIV = 25000000,
    localparam int W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_shift_left,
    input  logic                i_shift_right,
    input  logic                i_load,
    input  logic [W-1:0]        i_load_pos,
    input  logic [N_DIGITS-1:0] i_active_mask,
    output logic [N_DIGITS-1:0] o_digit_select,
    output logic [W-1:0]        o_pos,
    output logic                o_blocked,
    output logic [N_DIGITS-1:0] o_blink_mask
);

    localparam logic [N_DIGITS-1:0] RESET_SEL = N_DIGITS'(1) << RESET_POS;

    if (N_DIGITS < 2 || RESET_POS < 0 || RESET_POS >= N_DIGITS || BLINK_DIV < 1) begin : g_param_check
        $error("digit_cursor_ctrl: illegal parameter combination");
    end

    logic [W-1:0]        pos_q, pos_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic                blocked_q, blocked_d;
    logic                moved;

    logic [N_DIGITS-1:0] above_en;
    logic [N_DIGITS-1:0] below_en;
    logic [N_DIGITS-1:0] load_hit;
    logic [N_DIGITS-1:0] pos_onehot;
    logic                mask_any;
    logic                cur_en;
    logic                load_ok;

    // Per-digit candidate vectors; indices at or beyond N_DIGITS never hit load_hit.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign above_en[gi]   = i_active_mask[gi] && (W'(gi) > pos_q);
        assign below_en[gi]   = i_active_mask[gi] && (W'(gi) < pos_q);
        assign load_hit[gi]   = i_active_mask[gi] && (i_load_pos == W'(gi));
        assign pos_onehot[gi] = (pos_d == W'(gi));
    end

    assign mask_any = |i_active_mask;
    assign cur_en   = |(sel_q & i_active_mask);
    assign load_ok  = |load_hit;

    function automatic logic [W-1:0] lowest_idx(input logic [N_DIGITS-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic [W-1:0] highest_idx(input logic [N_DIGITS-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        pos_d     = pos_q;
        blocked_d = 1'b0;
        moved     = 1'b0;
        if (!mask_any) begin
            blocked_d = i_load | i_shift_left | i_shift_right;
        end else if (sel_q == '0 || !cur_en) begin
            // Cursor is invisible or sits on a disabled digit: requests wait a cycle.
            pos_d = lowest_idx(i_active_mask);
            moved = 1'b1;
        end else if (i_load) begin
            if (load_ok) begin
                pos_d = i_load_pos;
                moved = 1'b1;
            end else begin
                blocked_d = 1'b1;
            end
        end else if (i_shift_left && i_shift_right) begin
            blocked_d = 1'b1;
        end else if (i_shift_left) begin
            if (|above_en) begin
                pos_d = lowest_idx(above_en);
                moved = 1'b1;
            end else if (WRAP != 0 && lowest_idx(i_active_mask) != pos_q) begin
                pos_d = lowest_idx(i_active_mask);
                moved = 1'b1;
            end else begin
                blocked_d = 1'b1;
            end
        end else if (i_shift_right) begin
            if (|below_en) begin
                pos_d = highest_idx(below_en);
                moved = 1'b1;
            end else if (WRAP != 0 && highest_idx(i_active_mask) != pos_q) begin
                pos_d = highest_idx(i_active_mask);
                moved = 1'b1;
            end else begin
                blocked_d = 1'b1;
            end
        end
    end

    assign sel_d = !mask_any ? '0 : (moved ? pos_onehot : sel_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_q     <= W'(RESET_POS);
            sel_q     <= RESET_SEL;
            blocked_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            sel_q     <= sel_d;
            blocked_q <= blocked_d;
        end
    end

    assign o_pos          = pos_q;
    assign o_digit_select = sel_q;
    assign o_blocked      = blocked_q;

`ifdef CURSOR_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [N_DIGITS-1:0] blink_mask_q;

    // Any accepted cursor change restarts the on-phase so the new digit shows at once.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + CW'(1);
        blink_phase_d = blink_phase_q;
        if (moved) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            blink_mask_q  <= RESET_SEL;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_mask_q  <= blink_phase_d ? sel_d : '0;
        end
    end

    assign o_blink_mask = blink_mask_q;
`else
    assign o_blink_mask = sel_q;
`endif

endmodule

// File: tb/tb_digit_cursor_ctrl.sv
// Directed and random checks of digit_cursor_ctrl (wrap and clamp instances)
// against a search-based reference model of the cursor rules.
module tb_digit_cursor_ctrl;
    localparam int N  = 4;
    localparam int W  = 2;
    localparam int BD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, sl, sr, ld;
    logic [W-1:0] lp;
    logic [N-1:0] mask;

    logic [N-1:0] sel_a, sel_b, blm_a, blm_b;
    logic [W-1:0] pos_a, pos_b;
    logic         blk_a, blk_b;

    digit_cursor_ctrl #(.N_DIGITS(N), .WRAP(1), .RESET_POS(0), .BLINK_DIV(BD)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_shift_left(sl), .i_shift_right(sr), .i_load(ld),
        .i_load_pos(lp), .i_active_mask(mask), .o_digit_select(sel_a), .o_pos(pos_a),
        .o_blocked(blk_a), .o_blink_mask(blm_a));

    digit_cursor_ctrl #(.N_DIGITS(N), .WRAP(0), .RESET_POS(0), .BLINK_DIV(BD)) u_clamp (
        .i_clk(clk), .i_rst(rst), .i_shift_left(sl), .i_shift_right(sr), .i_load(ld),
        .i_load_pos(lp), .i_active_mask(mask), .o_digit_select(sel_b), .o_pos(pos_b),
        .o_blocked(blk_b), .o_blink_mask(blm_b));

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 = wrap instance, 1 = clamp instance.
    int m_pos[2];
    bit m_vis[2];
    bit m_blk[2];
    bit m_ph[2];
    int m_cnt[2];

    // Walk away from 'from' in steps of dir; wrapping instances continue past the ends.
    function automatic int seek(input int w, input int from, input int dir);
        for (int k = 1; k < N; k++) begin
            int c;
            c = from + dir * k;
            if (c >= 0 && c < N) begin
                if (mask[c]) return c;
            end else if (w == 0) begin
                if (mask[(c + N) % N]) return (c + N) % N;
            end
        end
        return -1;
    endfunction

    function automatic int lowest_enabled();
        for (int i = 0; i < N; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            bit restart;
            int t;
            restart = 1'b0;
            if (rst) begin
                m_pos[w] = 0; m_vis[w] = 1'b1; m_blk[w] = 1'b0; m_cnt[w] = 0; m_ph[w] = 1'b1;
            end else begin
                m_blk[w] = 1'b0;
                if (mask == '0) begin
                    m_vis[w] = 1'b0;
                    m_blk[w] = ld | sl | sr;
                end else if (!m_vis[w] || !mask[m_pos[w]]) begin
                    m_pos[w] = lowest_enabled(); m_vis[w] = 1'b1; restart = 1'b1;
                end else if (ld) begin
                    if (int'(lp) < N && mask[lp]) begin m_pos[w] = int'(lp); restart = 1'b1; end
                    else m_blk[w] = 1'b1;
                end else if (sl && sr) begin
                    m_blk[w] = 1'b1;
                end else if (sl || sr) begin
                    t = seek(w, m_pos[w], sl ? 1 : -1);
                    if (t < 0) m_blk[w] = 1'b1;
                    else begin m_pos[w] = t; restart = 1'b1; end
                end
                if (restart) begin m_cnt[w] = 0; m_ph[w] = 1'b1; end
                else if (m_cnt[w] == BD - 1) begin m_cnt[w] = 0; m_ph[w] = ~m_ph[w]; end
                else m_cnt[w] = m_cnt[w] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sel(input int w);
        return m_vis[w] ? (32'd1 << m_pos[w]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_blink(input int w);
`ifdef CURSOR_BLINK_EN
        return m_ph[w] ? exp_sel(w) : 32'd0;
`else
        return exp_sel(w);
`endif
    endfunction

    task automatic check_all();
        chk("wrap_pos",    32'(pos_a), 32'(m_pos[0]));
        chk("wrap_sel",    32'(sel_a), exp_sel(0));
        chk("wrap_blk",    32'(blk_a), 32'(m_blk[0]));
        chk("wrap_blink",  32'(blm_a), exp_blink(0));
        chk("clamp_pos",   32'(pos_b), 32'(m_pos[1]));
        chk("clamp_sel",   32'(sel_b), exp_sel(1));
        chk("clamp_blk",   32'(blk_b), 32'(m_blk[1]));
        chk("clamp_blink", 32'(blm_b), exp_blink(1));
    endtask

    task automatic cyc(input bit r, input bit l, input bit rt, input bit lo,
                       input int p, input logic [N-1:0] m);
        rst = r; sl = l; sr = rt; ld = lo; lp = W'(p); mask = m;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        $display("step rst=%0b l=%0b r=%0b ld=%0b lp=%0d mask=%b | pos %0d/%0d sel %b/%b blk %0b/%0b",
                 r, l, rt, lo, p, m, pos_a, pos_b, sel_a, sel_b, blk_a, blk_b);
    endtask

    initial begin
        rst = 1'b1; sl = 1'b0; sr = 1'b0; ld = 1'b0; lp = '0; mask = 4'b1111;
        cyc(1, 0, 0, 0, 0, 4'b1111);
        cyc(1, 1, 1, 1, 3, 4'b1111);
        chk("reset_pos", 32'(pos_a), 32'd0);
        chk("reset_sel", 32'(sel_a), 32'd1);

        // Four lefts then one right.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 4'b1111);
        chk("t1_wrap_to_0", 32'(pos_a), 32'd0);
        chk("t2_clamp_blk", 32'(blk_b), 32'd1);
        cyc(0, 0, 1, 0, 0, 4'b1111);
        chk("t1_right_wrap", 32'(pos_a), 32'd3);
        chk("t2_clamp_right", 32'(pos_b), 32'd2);

        // Masked skip and rejected load.
        cyc(0, 0, 0, 0, 0, 4'b1011);
        cyc(0, 0, 0, 1, 1, 4'b1011);
        cyc(0, 1, 0, 0, 0, 4'b1011);
        chk("t3_skip", 32'(pos_a), 32'd3);
        cyc(0, 0, 0, 1, 2, 4'b1011);
        chk("t3_load_blk", 32'(blk_a), 32'd1);
        cyc(0, 0, 0, 0, 0, 4'b1011);

        // Relocation on disable, empty mask, reappearance.
        cyc(0, 0, 0, 1, 2, 4'b1111);
        cyc(0, 0, 0, 0, 0, 4'b1011);
        chk("t4_reloc", 32'(pos_a), 32'd0);
        cyc(0, 1, 0, 0, 0, 4'b0000);
        chk("t4_empty_sel", 32'(sel_b), 32'd0);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        cyc(0, 1, 0, 1, 0, 4'b0100);
        chk("t4_reappear", 32'(pos_b), 32'd2);

        // Conflicting requests, load priority, single enabled digit.
        cyc(0, 1, 1, 0, 0, 4'b1111);
        cyc(0, 1, 0, 1, 0, 4'b1111);
        chk("t5_load_wins", 32'(pos_a), 32'd0);
        cyc(0, 1, 0, 0, 0, 4'b0001);
        cyc(0, 0, 1, 0, 0, 4'b0001);

        // Idle long enough to see blink phases, then move mid-phase.
        for (int i = 0; i < 13; i++) cyc(0, 0, 0, 0, 0, 4'b1111);
        cyc(0, 1, 0, 0, 0, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'b1111);
        cyc(1, 1, 0, 0, 0, 4'b1111);

        // Random phase with slowly changing masks.
        begin
            logic [N-1:0] rm;
            rm = 4'b1111;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0)
                    rm = ($urandom_range(0, 9) < 5) ? 4'b1111 : N'($urandom_range(0, 15));
                cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, N - 1)), rm);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
